adc_responder: RTL and testbench

ADC_RESPONDER -- requirements
Module: adc_responder

---
 rtl/adc_responder.sv | 74 +++++++
 tb/tb_adc_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_responder.sv
// Behavioural ADC model: a rising edge on wr starts a fixed-length conversion.
// intr is high while converting; its falling edge coincides with done and a new adc value.
module adc_responder #(
  parameter int unsigned CONV_CYCLES = 350,
  parameter bit          RAMP        = 1'b0,
  parameter logic [7:0]  INIT_VALUE  = 8'h95
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] sample_in,
  output logic       intr,
  output logic [7:0] adc,
  output logic       done,
  output logic       overrun
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       smp;
  logic             wr_d;
  logic             wr_rise;

  // wr_d resets high so a wr already asserted at reset release is not an edge
  assign wr_rise = wr & ~wr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      intr    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      adc     <= INIT_VALUE;
      smp     <= INIT_VALUE;
      cnt     <= '0;
      wr_d    <= 1'b1;
    end else begin
      wr_d <= wr;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_rise) begin
            state <= CONV;
            intr  <= 1'b1;
            cnt   <= CNT_LOAD;
            smp   <= RAMP ? 8'(adc + 8'd1) : sample_in;
          end
        end
        CONV: begin
          // edges during a conversion are flagged, never restart it
          if (wr_rise) overrun <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= IDLE;
            intr  <= 1'b0;
            adc   <= smp;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          intr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench: dut0 converts sample_in (4-cycle conversion), dut1 runs the ramp
// with the default 350-cycle conversion starting from 8'hFE.
module tb_adc_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr0 = 1'b0;
  logic       wr1 = 1'b0;
  logic [7:0] s0  = 8'h00;
  logic [7:0] s1  = 8'h00;
  logic       intr0, done0, ovr0;
  logic       intr1, done1, ovr1;
  logic [7:0] adc0, adc1;

  int tests  = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #10 clk = ~clk;

  adc_responder #(.CONV_CYCLES(4), .RAMP(1'b0), .INIT_VALUE(8'h95)) dut0 (
    .clk(clk), .rst(rst), .wr(wr0), .sample_in(s0),
    .intr(intr0), .adc(adc0), .done(done0), .overrun(ovr0)
  );

  adc_responder #(.CONV_CYCLES(350), .RAMP(1'b1), .INIT_VALUE(8'hFE)) dut1 (
    .clk(clk), .rst(rst), .wr(wr1), .sample_in(s1),
    .intr(intr1), .adc(adc1), .done(done1), .overrun(ovr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // dut0 monitor: every done must match the oldest queued result after exactly 4 intr cycles
  int hi0 = 0;
  logic [7:0] e0;
  always @(negedge clk) begin
    if (rst) hi0 = 0;
    else begin
      if (intr0) hi0++;
      if (done0) begin
        chk("dut0_done_intr_excl", 32'(intr0), 32'd0);
        chk("dut0_intr_width", 32'(hi0), 32'd4);
        hi0 = 0;
        if (q0.size() == 0) chk("dut0_unexpected_done", 32'd1, 32'd0);
        else begin
          e0 = q0.pop_front();
          chk("dut0_adc", 32'(adc0), 32'(e0));
        end
      end
    end
  end

  // dut1 monitor: intr high time per conversion is 350 clocks of 20 time units
  longint rise_t = 0;
  logic prev1 = 1'b0;
  logic [7:0] e1;
  always @(negedge clk) begin
    if (intr1 && !prev1) rise_t = $time;
    prev1 = intr1;
    if (!rst && done1) begin
      chk("dut1_done_intr_excl", 32'(intr1), 32'd0);
      chk("dut1_intr_time", 32'($time - rise_t), 32'd7000);
      if (q1.size() == 0) chk("dut1_unexpected_done", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("dut1_adc", 32'(adc1), 32'(e1));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // called at a negedge; leaves off at the negedge of the first intr cycle
  task automatic start0(input logic [7:0] v);
    s0  = v;
    wr0 = 1'b1;
    @(negedge clk);
    chk("dut0_edge_to_intr", 32'(intr0), 32'd1);
    wr0 = 1'b0;
    s0  = ~v;
  endtask

  task automatic wait_done0(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done0) return;
    end
    chk("dut0_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done1(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done1) return;
    end
    chk("dut1_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic start1(input logic [7:0] exp);
    q1.push_back(exp);
    wr1 = 1'b1;
    @(negedge clk);
    chk("dut1_edge_to_intr", 32'(intr1), 32'd1);
    wr1 = 1'b0;
  endtask

  int ndone;

  initial begin
    do_reset();
    chk("rst_intr", 32'(intr0), 32'd0);
    chk("rst_adc", 32'(adc0), 32'h95);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_overrun", 32'(ovr0), 32'd0);
    chk("rst_adc_ramp", 32'(adc1), 32'hFE);

    // basic conversion; sample_in changes after the edge must not matter
    q0.push_back(8'h3C);
    start0(8'h3C);
    wait_done0(20);
    // back-to-back: edge seen in the done cycle itself
    q0.push_back(8'h5A);
    start0(8'h5A);
    wait_done0(20);
    chk("adc_stable_idle", 32'(adc0), 32'h5A);

    // second edge during conversion: overrun, no restart, single done
    @(negedge clk);
    q0.push_back(8'hA5);
    start0(8'hA5);
    @(negedge clk);
    wr0 = 1'b1;
    @(negedge clk);
    chk("overrun_set", 32'(ovr0), 32'd1);
    wr0 = 1'b0;
    wait_done0(20);
    repeat (6) @(negedge clk);
    chk("overrun_sticky", 32'(ovr0), 32'd1);
    chk("adc_after_overrun", 32'(adc0), 32'hA5);

    // wr held high across reset release must not start a conversion
    wr0 = 1'b1;
    do_reset();
    chk("overrun_cleared", 32'(ovr0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("held_wr_no_intr", 32'(intr0), 32'd0);
      @(negedge clk);
    end
    wr0 = 1'b0;
    @(negedge clk);
    q0.push_back(8'h77);
    start0(8'h77);
    wait_done0(20);

    // reset two cycles into a conversion discards the result
    @(negedge clk);
    start0(8'hAA);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_intr", 32'(intr0), 32'd0);
    chk("abort_adc", 32'(adc0), 32'h95);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_adc_hold", 32'(adc0), 32'h95);

    // ramp with wrap FE -> FF -> 00 -> 01
    start1(8'hFF);
    wait_done1(400);
    @(negedge clk);
    start1(8'h00);
    wait_done1(400);
    @(negedge clk);
    start1(8'h01);
    wait_done1(400);
    chk("ramp_no_overrun", 32'(ovr1), 32'd0);

    repeat (4) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
